// File: rtl/gcd_pkg.sv
// Shared types and mux-select encodings for the GCD controller.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_A_LOAD = 2'b00;
  localparam logic [1:0] SEL_A_SUB  = 2'b01;
  localparam logic [1:0] SEL_A_SWAP = 2'b10;
  localparam logic [1:0] SEL_A_ZERO = 2'b11;

  localparam logic [1:0] SEL_B_LOAD = 2'b00;
  localparam logic [1:0] SEL_B_SWAP = 2'b01;
  localparam logic [1:0] SEL_B_HOLD = 2'b10;
  localparam logic [1:0] SEL_B_ZERO = 2'b11;

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating operation counter: clears on accept, counts subtract/swap cycles.
module gcd_iter_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/gcd_ctrl.sv
// Control FSM for a subtract/swap GCD datapath.
// Optional iteration counter built when GCD_CTRL_ITER_CNT_EN is defined.
//
// state | meaning
// IDLE  | ready for operands; loads A/B on req_val
// CALC  | subtract (A>=B) or swap (A<B) until B==0
// WAIT  | one quiet cycle so the result register captures A
// DONE  | result valid, held until resp_rdy
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int ITER_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_val,
  output logic              req_rdy,
  output logic              resp_val,
  input  logic              resp_rdy,
  input  logic              beq0,
  input  logic              agtb,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              en_a,
  output logic              en_b,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_val) begin
          state   <= CALC;
          req_rdy <= 1'b0;
        end
        CALC: if (beq0) state <= WAIT;
        WAIT: begin
          state    <= DONE;
          resp_val <= 1'b1;
        end
        DONE: if (resp_rdy) begin
          state    <= IDLE;
          resp_val <= 1'b0;
          req_rdy  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enables must react to beq0/agtb in the same cycle, so they are decoded combinationally.
  always_comb begin
    en_a  = 1'b0;
    en_b  = 1'b0;
    sel_a = SEL_A_LOAD;
    sel_b = SEL_B_LOAD;
    if (rst_n) begin
      case (state)
        IDLE: if (req_val) begin
          en_a = 1'b1;
          en_b = 1'b1;
        end
        CALC: if (!beq0) begin
          if (agtb) begin
            sel_a = SEL_A_SUB;
            en_a  = 1'b1;
          end else begin
            sel_a = SEL_A_SWAP;
            sel_b = SEL_B_SWAP;
            en_a  = 1'b1;
            en_b  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GCD_CTRL_ITER_CNT_EN
  logic cnt_clr;
  logic cnt_inc;

  assign cnt_clr = (state == IDLE) && req_val;
  assign cnt_inc = (state == CALC) && !beq0;

  gcd_iter_counter #(.W(ITER_W)) u_iter_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (iter_cnt)
  );
`else
  assign iter_cnt = '0;
`endif

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 SHALL have parameter ITER_W, default 9, giving the iteration counter width. Nine bits cover the 8-bit worst case of 256 operations.
REQ-002 SHALL have clk, input, 1, clock; all logic on posedge.
REQ-003 SHALL have rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have req_val, input, 1, operands on the datapath a/b inputs are valid.
REQ-005 SHALL have req_rdy, output, 1, controller can accept operands.
REQ-006 SHALL have resp_val, output, 1, datapath result output holds the GCD.
REQ-007 SHALL have resp_rdy, input, 1, consumer accepts the result.
REQ-008 SHALL have beq0, input, 1, datapath B register equals 0.
REQ-009 SHALL have agtb, input, 1, datapath A register >= B register.
REQ-010 SHALL have sel_a, output, 2, A mux select: 00 load a, 01 A-B, 10 B, 11 zero.
REQ-011 SHALL have sel_b, output, 2, B mux select: 00 load b, 01 A, 10 hold B, 11 zero.
REQ-012 SHALL have en_a and en_b, outputs, 1 each, A/B register load enables.
REQ-013 SHALL have iter_cnt, output, ITER_W, number of datapath operations in the current or last computation.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, CALC, WAIT, DONE.
REQ-015 SHALL assert req_rdy only in IDLE; resp_val only in DONE; both are registered state decodes.
REQ-016 IDLE: on req_val&req_rdy, SHALL drive sel_a=00, sel_b=00, en_a=en_b=1 in that cycle, then go to CALC.
REQ-017 CALC, beq0=1: SHALL drive en_a=en_b=0 and go to WAIT.
REQ-018 CALC, beq0=0, agtb=1: SHALL drive sel_a=01, en_a=1, en_b=0 (subtract); stay in CALC.
REQ-019 CALC, beq0=0, agtb=0: SHALL drive sel_a=10, sel_b=01, en_a=en_b=1 (swap); stay in CALC.
REQ-020 WAIT: SHALL hold en_a=en_b=0 for one cycle so the datapath result register captures A, then go to DONE.
REQ-021 DONE: SHALL hold en_a=en_b=0 and stay in DONE while resp_rdy=0; on resp_val&resp_rdy, SHALL return to IDLE.
REQ-022 Outside the cases in REQ-016 to REQ-019, SHALL drive en_a=en_b=0 and sel_a=sel_b=00.
REQ-023 SHALL ignore req_val outside IDLE; the new request may only be taken in the cycle after the DONE handshake.
REQ-024 Latency: SHALL assert resp_val exactly 3+N cycles after the accept cycle, where N is the count of subtract plus swap operations.
REQ-025 Boundary b=0: N=0 and the result equals a.
REQ-026 Boundary a=0, b!=0: one swap, then the result equals b.
REQ-027 Boundary a=b=0: N=0 and the result is 0.
REQ-028 iter_cnt: SHALL clear on accept, increment once per subtract or swap cycle, saturate at all-ones, and hold its value through DONE and IDLE.

Reset
REQ-029 While rst_n=0, SHALL put the FSM in IDLE; req_rdy=1, resp_val=0, en_a=en_b=0, sel_a=sel_b=00, iter_cnt=0.
REQ-030 Reset asserted mid-computation SHALL abort it; no resp_val for the aborted request.

Configuration
REQ-031 Macro GCD_CTRL_ITER_CNT_EN: when defined, the iteration counter SHALL be built and behave per REQ-028.
REQ-032 When GCD_CTRL_ITER_CNT_EN is undefined, SHALL build no counter flops and tie iter_cnt to 0; FSM behaviour is unchanged.

Structure
REQ-033 Package gcd_pkg SHALL hold the state enum (IDLE/CALC/WAIT/DONE) and the constants SEL_A_LOAD/SUB/SWAP/ZERO and SEL_B_LOAD/SWAP/HOLD/ZERO.
REQ-034 Sub-module gcd_iter_counter SHALL implement the clear/increment/saturate counter; it is instantiated only under GCD_CTRL_ITER_CNT_EN.

Verification
REQ-035 Datapath plus controller, a=12, b=8, accepted at cycle T: resp_val at T+8, res=4, iter_cnt=5.
REQ-036 a=9, b=0: resp_val at T+3, res=9, iter_cnt=0.
REQ-037 a=0, b=7: res=7, iter_cnt=1; a=0, b=0: res=0, iter_cnt=0.
REQ-038 a=255, b=1, with resp_rdy held 0 for 10 cycles: resp_val stays 1 and res stays 1; iter_cnt=256; return to IDLE in the cycle after resp_rdy=1.
REQ-039 Second req_val raised during CALC: req_rdy=0 and the request is not accepted; it is accepted in IDLE after the first response.
REQ-040 rst_n=0 pulsed during CALC: next cycle state is IDLE, req_rdy=1, resp_val never asserts; a fresh a=21, b=14 then gives res=7.
